line_clear_ctrl: RTL
====================

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 SHALL have parameter BOARD_W, default 12, the number of board columns (column 0..11).
REQ-002 SHALL have parameter BOARD_H, default 19, the number of board rows (row 0 top, row 18 bottom).
REQ-003 SHALL have port Clk, input, 1, the single system clock.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to scan the board after a piece locks.
REQ-006 SHALL have port busy, output, 1, high while the controller owns the board port; the external mux grants the board to it when high.
REQ-007 SHALL have port row_addr, output, 5, the board row address.
REQ-008 SHALL have port rd_data, input, 16, the board row read data, valid one cycle after row_addr (synchronous read).
REQ-009 SHALL have port wr_en, output, 1, the board row write strobe.
REQ-010 SHALL have port wr_data, output, 16, the board row write data.
REQ-011 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port lines_cleared, output, 3, the count of rows cleared by the last scan.
REQ-013 SHALL have port score_add, output, 11, the score increment for the last scan.

Function
REQ-014 SHALL use states IDLE, READ, CHECK, SHIFT_RD, SHIFT_WR and DONE; busy is high in every state except IDLE.
REQ-015 IDLE: on start, SHALL set scan_row=BOARD_H-1, clear the line counter and go to READ; start is ignored in every other state.
REQ-016 READ: SHALL drive row_addr=scan_row, then go to CHECK.
REQ-017 CHECK: a row is full when rd_data[BOARD_W-1:0] is all ones; bits above BOARD_W-1 are ignored.
REQ-018 CHECK, full row: SHALL set shift_row=scan_row, increment the line counter (saturating at 7) and go to SHIFT_RD.
REQ-019 CHECK, not full: if scan_row==0, SHALL go to DONE; otherwise SHALL decrement scan_row and go to READ.
REQ-020 SHIFT_RD: if shift_row>0, SHALL drive row_addr=shift_row-1; in either case SHALL go to SHIFT_WR.
REQ-021 SHIFT_WR: SHALL drive wr_en=1 and row_addr=shift_row for exactly one cycle.
REQ-022 SHIFT_WR write data: wr_data={4'b0, rd_data[11:0]} when shift_row>0; wr_data=0 when shift_row==0.
REQ-023 SHIFT_WR exit: if shift_row==0, SHALL go to READ with scan_row unchanged, so the same row is rechecked; otherwise SHALL decrement shift_row and go to SHIFT_RD.
REQ-024 DONE: SHALL pulse done for one cycle, latch lines_cleared and score_add, then go to IDLE.
REQ-025 score_add SHALL map lines 0/1/2/3/4 to 0/40/100/300/1200, and any count of 5 or more to 1200.
REQ-026 lines_cleared and score_add SHALL hold their values until the next DONE.
REQ-027 wr_en SHALL be 0 outside SHIFT_WR.
REQ-028 row_addr SHALL be 0 in IDLE and DONE.
REQ-029 Latency: with no full rows, done SHALL be high exactly 39 cycles after the start-sampling edge.
REQ-030 Each full row at index r SHALL add 2(r+1)+2 cycles to the latency.

Reset
REQ-031 Reset SHALL force state=IDLE, busy=0, done=0, wr_en=0, row_addr=0, lines_cleared=0, score_add=0 and all internal counters to 0, asynchronously.
REQ-032 Reset asserted mid-scan or mid-shift SHALL abort immediately, issue no further writes and produce no done pulse.

Structure
REQ-033 A shared package line_clear_pkg SHALL hold BOARD_W, BOARD_H, the FULL_ROW mask, the state enum and the score table constants.
REQ-034 The single sub-module score_lut SHALL be purely combinational and map the 3-bit line count to the 11-bit score_add.

Verification
REQ-035 Empty board, start at edge k -> done at k+39, lines_cleared=0, score_add=0, no wr_en pulse.
REQ-036 Row 18 = 0xFFF, row 17 = 0x0A5 -> after done, row 18 = 0x0A5, row 0 = 0, lines_cleared=1, score_add=40, done at k+39+40.
REQ-037 Rows 15..18 full, rows 0..14 empty -> all rows 0, lines_cleared=4, score_add=1200.
REQ-038 Rows 18 and 16 full, row 17 = 0x001 -> row 18 = 0x001, lines_cleared=2, score_add=100.
REQ-039 Row 0 full only -> row 0 written 0, lines_cleared=1.
REQ-040 start pulsed while busy -> ignored; Reset during SHIFT_WR -> busy=0 next cycle, no done, no further writes.

Source files
------------

// File: rtl/line_clear_pkg.sv
// line_clear_pkg: shared constants and types for the line-clear controller.
//   BOARD_W / BOARD_H : board geometry (columns / rows, row 0 at the top)
//   ROW_BITS          : width of one board row word on the board port
//   FULL_ROW          : mask of the occupied-column bits of a row word
//   state_t           : controller FSM states
//   SCORE_*           : score awarded per number of rows cleared in one scan
package line_clear_pkg;

    localparam int BOARD_W  = 12;
    localparam int BOARD_H  = 19;
    localparam int ROW_BITS = 16;

    localparam logic [ROW_BITS-1:0] FULL_ROW = 16'h0FFF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        SHIFT_RD,
        SHIFT_WR,
        DONE
    } state_t;

    localparam logic [10:0] SCORE_0 = 11'd0;
    localparam logic [10:0] SCORE_1 = 11'd40;
    localparam logic [10:0] SCORE_2 = 11'd100;
    localparam logic [10:0] SCORE_3 = 11'd300;
    localparam logic [10:0] SCORE_4 = 11'd1200;

endpackage

// File: rtl/score_lut.sv
// score_lut: combinational map from rows cleared in one scan to score.
//   lines : saturated count of rows cleared (0..7)
//   score : score increment; four or more rows all earn the top award
module score_lut
    import line_clear_pkg::*;
(
    input  logic [2:0]  lines,
    output logic [10:0] score
);

    always_comb begin
        score = SCORE_4;
        case (lines)
            3'd0:    score = SCORE_0;
            3'd1:    score = SCORE_1;
            3'd2:    score = SCORE_2;
            3'd3:    score = SCORE_3;
            default: score = SCORE_4;
        endcase
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: after a piece locks, scans the board bottom-up, removes
// every full row by shifting all rows above it down by one, then reports
// the number of rows cleared and the resulting score.
//   Clk, Reset     : system clock, asynchronous active-high reset
//   start          : one-cycle scan request (honoured only when idle)
//   busy           : controller owns the board port
//   row_addr       : board row address (synchronous read, data next cycle)
//   rd_data        : board row read data
//   wr_en, wr_data : board row write strobe / data
//   done           : one-cycle completion pulse
//   lines_cleared  : rows cleared by the last scan (saturates at 7)
//   score_add      : score increment for the last scan
module line_clear_ctrl
    import line_clear_pkg::*;
#(
    parameter int BOARD_W = line_clear_pkg::BOARD_W,
    parameter int BOARD_H = line_clear_pkg::BOARD_H
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    output logic        busy,
    output logic [4:0]  row_addr,
    input  logic [15:0] rd_data,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        done,
    output logic [2:0]  lines_cleared,
    output logic [10:0] score_add
);

    localparam logic [15:0] ROW_MASK = 16'((32'd1 << BOARD_W) - 32'd1);
    localparam logic [4:0]  LAST_ROW = 5'(BOARD_H - 1);

    state_t      state, state_nxt;
    logic [4:0]  scan_row, scan_nxt;
    logic [4:0]  shift_row, shift_nxt;
    logic [2:0]  line_cnt, cnt_nxt;
    logic [10:0] score_nxt;
    logic        row_full;

    assign row_full = (rd_data & ROW_MASK) == ROW_MASK;
    assign busy     = (state != IDLE);

    score_lut u_score (
        .lines (line_cnt),
        .score (score_nxt)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            scan_row  <= '0;
            shift_row <= '0;
            line_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            scan_row  <= scan_nxt;
            shift_row <= shift_nxt;
            line_cnt  <= cnt_nxt;
        end
    end

    // Result registers update on the edge that leaves DONE, so done and
    // the new results appear together and hold until the next scan ends.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            done          <= 1'b0;
            lines_cleared <= '0;
            score_add     <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                lines_cleared <= line_cnt;
                score_add     <= score_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        scan_nxt  = scan_row;
        shift_nxt = shift_row;
        cnt_nxt   = line_cnt;
        row_addr  = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    scan_nxt  = LAST_ROW;
                    cnt_nxt   = '0;
                    state_nxt = READ;
                end
            end
            READ: begin
                row_addr  = scan_row;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (row_full) begin
                    shift_nxt = scan_row;
                    cnt_nxt   = (line_cnt == 3'd7) ? 3'd7 : line_cnt + 3'd1;
                    state_nxt = SHIFT_RD;
                end else if (scan_row == '0) begin
                    state_nxt = DONE;
                end else begin
                    scan_nxt  = scan_row - 5'd1;
                    state_nxt = READ;
                end
            end
            SHIFT_RD: begin
                // Fetch the row above; the top row has nothing above it.
                if (shift_row != '0)
                    row_addr = shift_row - 5'd1;
                state_nxt = SHIFT_WR;
            end
            SHIFT_WR: begin
                wr_en    = 1'b1;
                row_addr = shift_row;
                if (shift_row != '0) begin
                    wr_data   = rd_data & ROW_MASK;
                    shift_nxt = shift_row - 5'd1;
                    state_nxt = SHIFT_RD;
                end else begin
                    // Sweep finished: re-read the same scan row, since a
                    // full row may have just dropped into it.
                    state_nxt = READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
